// File: rtl/seq_controller.sv
// seq_controller: Moore FSM that sequences one N-cycle shift operation.
// It arms an external iteration counter, enables the datapath while the
// counter runs, and reports done or a watchdog error until acknowledged.
module seq_controller #(
  parameter int N = 4,
  parameter int W = $clog2(N + 3)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  input  logic ov_counter,
  input  logic able,
  output logic load,
  output logic shift_en,
  output logic ready,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  // The watchdog register holds the number of RUN cycles already completed,
  // so it reaches N+2 at the end of the (N+2)th RUN cycle when it shows N+1.
  localparam logic [W-1:0] WD_LAST = W'(N + 1);
  localparam logic [W-1:0] WD_MAX  = '1;

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  logic [W-1:0] r_wd;
  logic         w_expire;

  assign w_expire = (r_wd >= WD_LAST);

  // Next-state selection; ov_counter takes priority over watchdog expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN: begin
        if (ov_counter)    w_next = S_DONE;
        else if (w_expire) w_next = S_ERROR;
      end
      S_DONE:  if (ack) w_next = S_IDLE;
      S_ERROR: if (ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Watchdog: held at zero outside RUN so every RUN entry starts clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_wd <= '0;
    else if (r_state != S_RUN) r_wd <= '0;
    else if (r_wd != WD_MAX)  r_wd <= r_wd + 1'b1;
  end

  assign load     = (r_state == S_LOAD);
  assign ready    = (r_state == S_IDLE);
  assign busy     = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERROR);
  assign shift_en = (r_state == S_RUN) && able && !ov_counter;

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: randomized bench for seq_controller with a behavioural
// iteration-counter model and per-operation expected timelines.
module tb_seq_controller;

  localparam int N = 4;

  localparam logic [5:0] EXP_IDLE = 6'b001000;
  localparam logic [5:0] EXP_LOAD = 6'b100100;
  localparam logic [5:0] EXP_DONE = 6'b000010;
  localparam logic [5:0] EXP_ERR  = 6'b000001;

  logic clk = 1'b0;
  logic rst, start, ack, ovCounter, able;
  logic load, shiftEn, ready, busy, done, err;

  int testCount = 0;
  int failCount = 0;
  int ctrCount  = N;

  seq_controller #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ack        (ack),
    .ov_counter (ovCounter),
    .able       (able),
    .load       (load),
    .shift_en   (shiftEn),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {load, shiftEn, ready, busy, done, err};
  endfunction

  task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b (load,shift_en,ready,busy,done,err)",
               tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic o, input logic e);
    start     = s;
    ack       = a;
    ovCounter = o;
    able      = e;
  endtask

  task automatic sampleCycle(input string tag, input logic [5:0] expected);
    @(negedge clk);
    checkOutput(tag, outs(), expected);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), ctrCount == N, 1'($urandom_range(0, 1)));
      sampleCycle("idle gap", EXP_IDLE);
    end
  endtask

  // mode: 0 counter runs freely, 1 ov_counter tied low, 2 one able drop,
  //       3 reset in third RUN cycle, 4 random able
  task automatic doOp(input int opId, input int mode, input bit holdStart, input int ackDelay);
    logic ovNow, ableNow;
    logic [5:0] finalExp;
    finalExp = EXP_ERR;

    applyStimulus(1'b1, 1'($urandom_range(0, 1)), ctrCount == N, 1'($urandom_range(0, 1)));
    sampleCycle($sformatf("op%0d idle", opId), EXP_IDLE);

    applyStimulus(holdStart ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ctrCount == N, 1'($urandom_range(0, 1)));
    sampleCycle($sformatf("op%0d load", opId), EXP_LOAD);
    ctrCount = 0;

    for (int r = 1; r <= N + 2; r++) begin
      case (mode)
        2:       ableNow = (r != 2);
        4:       ableNow = ($urandom_range(0, 5) != 0);
        default: ableNow = 1'b1;
      endcase
      ovNow = (mode == 1) ? 1'b0 : (ctrCount == N);
      applyStimulus(holdStart ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ovNow, ableNow);
      if (mode == 3 && r == 3) begin
        #2 rst = 1'b0;
        #1 checkOutput($sformatf("op%0d async reset", opId), outs(), EXP_IDLE);
        @(negedge clk);
        checkOutput($sformatf("op%0d reset held", opId), outs(), EXP_IDLE);
        @(posedge clk);
        #2 rst = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        idleCycles(3);
        return;
      end
      sampleCycle($sformatf("op%0d run%0d", opId, r), {1'b0, ableNow & ~ovNow, 4'b0100});
      if (ovNow) begin
        finalExp = EXP_DONE;
        break;
      end
      if (ableNow && ctrCount < N) ctrCount++;
    end

    for (int d = 0; d <= ackDelay; d++) begin
      applyStimulus(holdStart ? 1'b1 : 1'($urandom_range(0, 1)), d == ackDelay,
                    (mode == 1) ? 1'b0 : (ctrCount == N), 1'($urandom_range(0, 1)));
      sampleCycle($sformatf("op%0d final%0d", opId, d), finalExp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int mode;
    bit hold;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #2 checkOutput("reset state", outs(), EXP_IDLE);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    idleCycles(2);
    doOp(0, 0, 1'b0, 2);
    idleCycles(1);
    doOp(1, 1, 1'b0, 1);
    idleCycles(1);
    doOp(2, 2, 1'b0, 0);
    idleCycles(1);
    doOp(3, 0, 1'b1, 0);
    doOp(4, 0, 1'b1, 1);
    doOp(5, 0, 1'b0, 0);
    idleCycles(1);
    doOp(6, 3, 1'b0, 0);

    for (int op = 7; op < 40; op++) begin
      case ($urandom_range(0, 4))
        0:       mode = 0;
        1:       mode = 1;
        2:       mode = 2;
        default: mode = 4;
      endcase
      hold = 1'($urandom_range(0, 1));
      doOp(op, mode, hold, $urandom_range(0, 3));
      if (!hold) idleCycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter N, default 4, number of shift cycles per operation; SHALL equal N of the attached iteration counter, legal range 2..64.
REQ-002 Parameter W, default $clog2(N+3), watchdog counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 ack  input  1  upstream acknowledges done or err; sampled only in DONE and ERROR.
REQ-007 ov_counter  input  1  iteration counter finished flag, level, cleared by load.
REQ-008 able  input  1  iteration counter active flag.
REQ-009 load  output  1  one-cycle pulse that clears and arms the iteration counter.
REQ-010 shift_en  output  1  datapath shift/accumulate enable.
REQ-011 ready  output  1  controller idle, start accepted.
REQ-012 busy  output  1  operation in progress (LOAD or RUN).
REQ-013 done  output  1  result valid; held until ack.
REQ-014 err  output  1  watchdog expired; held until ack.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, LOAD, RUN, DONE, ERROR; load, ready, busy, done, err decode from the state register only.
REQ-016 IDLE: ready=1; start=1 -> LOAD; otherwise stay in IDLE; ov_counter and able are ignored.
REQ-017 LOAD: load=1 and busy=1 for exactly one cycle -> RUN unconditionally; start is ignored.
REQ-018 RUN: busy=1; shift_en = able AND NOT ov_counter, combinational, asserted in RUN only.
REQ-019 RUN: ov_counter=1 -> DONE; shift_en SHALL be 0 in that cycle.
REQ-020 Latency: start sampled at edge k -> load high cycle k+1 -> RUN from k+2 -> exactly N shift_en cycles (k+2..k+N+1) -> ov_counter seen in cycle k+N+2 -> done=1 from cycle k+N+3.
REQ-021 Watchdog: W-bit counter cleared on entry to RUN, increments every RUN cycle, saturates; if it reaches N+2 while ov_counter=0 -> ERROR.
REQ-022 ov_counter and watchdog expiry in the same RUN cycle: ov_counter wins -> DONE.
REQ-023 DONE: done=1, ready=0; ack=1 -> IDLE; start ignored while in DONE.
REQ-024 ERROR: err=1, shift_en=0, load=0; ack=1 -> IDLE.
REQ-025 ack in IDLE, LOAD or RUN SHALL have no effect.
REQ-026 At most one of ready, busy, done, err SHALL be high in any cycle; load SHALL never be high two consecutive cycles.
REQ-027 A stale ov_counter=1 left from a previous operation while in IDLE or LOAD SHALL NOT cause a transition.
REQ-028 start held high across DONE->IDLE SHALL launch the next operation one cycle after IDLE is entered (IDLE lasts one cycle).

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, watchdog=0, load=0, shift_en=0, busy=0, done=0, err=0, ready=1, independent of clk.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no load or done pulse emitted; after release the controller waits in IDLE for a new start.

Verification
REQ-031 N=4, start pulse one cycle with real counter attached -> load at k+1, shift_en high 4 cycles k+2..k+5, done=1 at k+7, held until ack, then ready=1 next cycle.
REQ-032 ov_counter tied 0 in RUN, N=4 -> err=1 after 6 RUN cycles, shift_en=0 in ERROR; ack -> IDLE, ready=1.
REQ-033 ov_counter and watchdog expiry in the same cycle -> done=1, err stays 0.
REQ-034 start held high continuously, ack pulsed in each DONE -> back-to-back operations, each with exactly one load pulse and N shift_en cycles.
REQ-035 rst pulled low at third RUN cycle -> all outputs at reset values asynchronously, ready=1 after release, no done.
REQ-036 ack and start toggled randomly in LOAD/RUN -> no state change, no extra load pulse, exactly N shift_en cycles.
